// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the hazard unit and its multi-cycle FSM.
// Rev 1.0
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_mc_fsm.sv
// hazard_mc_fsm: busy tracker for the multi-cycle execute unit with timeout watchdog.
// Rev 1.0
`default_nettype none

module hazard_mc_fsm
  import hazard_pkg::*;
#(
  parameter int MC_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic mc_start_e,
  input  logic mc_done,
  output logic mc_stall,
  output logic mc_timeout
);

  localparam int              CNT_W    = $clog2(MC_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

  mc_state_t        state_q, state_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic             mc_timeout_q, mc_timeout_d;
  logic             timeout_hit;

  // A late mc_done on the last allowed cycle still counts as a normal completion.
  assign timeout_hit = (state_q == BUSY) && (busy_cnt_q == CNT_LAST) && !mc_done;

  always_comb begin
    state_d      = state_q;
    busy_cnt_d   = busy_cnt_q;
    mc_timeout_d = mc_timeout_q;
    mc_stall     = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_cnt_d = '0;
        mc_stall   = mc_start_e;
        if (mc_start_e) state_d = BUSY;
      end
      BUSY: begin
        mc_stall = !mc_done && !timeout_hit;
        if (mc_done) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          state_d      = IDLE;
          mc_timeout_d = 1'b1;
        end else begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      busy_cnt_q   <= '0;
      mc_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_cnt_q   <= busy_cnt_d;
      mc_timeout_q <= mc_timeout_d;
    end
  end

  assign mc_timeout = mc_timeout_q;

endmodule

`default_nettype wire

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: forwarding, load-use/multi-cycle stalls, branch flushes, perf counters.
// Rev 1.0
`default_nettype none

module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int MC_TIMEOUT = 64,
  parameter int PERF_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*REG_AW-1:0] rs_d,
  input  logic [NUM_SRC-1:0]        rs_used_d,
  input  logic [NUM_SRC*REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0]         rd_e,
  input  logic [REG_AW-1:0]         rd_m,
  input  logic [REG_AW-1:0]         rd_w,
  input  logic                      reg_write_e,
  input  logic                      reg_write_m,
  input  logic                      reg_write_w,
  input  logic                      load_e,
  input  logic                      branch_taken_e,
  input  logic                      mc_start_e,
  input  logic                      mc_done,
  input  logic                      perf_clr,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      stall_e,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic                      flush_m,
  output logic                      mc_timeout,
  output logic [PERF_W-1:0]         stall_cnt,
  output logic [PERF_W-1:0]         flush_cnt
);

  logic              mc_stall;
  logic              src_hit;
  logic              lw_stall;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    logic [REG_AW-1:0] src;
    fwd_sel_t          sel;

    assign src = rs_e[i*REG_AW +: REG_AW];

    always_comb begin
      sel = FWD_NONE;
      if (reg_write_m && (src == rd_m) && (src != '0)) begin
        sel = FWD_M;
      end else if (reg_write_w && (src == rd_w) && (src != '0)) begin
        sel = FWD_W;
      end
    end

    assign fwd_sel[2*i +: 2] = sel;
  end

  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rs_used_d[i] && (rs_d[i*REG_AW +: REG_AW] == rd_e)) src_hit = 1'b1;
    end
  end

  assign lw_stall = load_e && reg_write_e && (rd_e != '0) && src_hit;

  hazard_mc_fsm #(
    .MC_TIMEOUT (MC_TIMEOUT)
  ) u_mc_fsm (
    .clk        (clk),
    .reset      (reset),
    .mc_start_e (mc_start_e),
    .mc_done    (mc_done),
    .mc_stall   (mc_stall),
    .mc_timeout (mc_timeout)
  );

  // The op held in E during a multi-cycle stall must never be killed.
  assign stall_f = lw_stall || mc_stall;
  assign stall_d = stall_f;
  assign stall_e = mc_stall;
  assign flush_m = mc_stall;
  assign flush_e = (lw_stall || branch_taken_e) && !mc_stall;
  assign flush_d = branch_taken_e && !mc_stall;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_f && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_d && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: directed literal checks plus randomized run against a behavioural model.
// Rev 1.0
`default_nettype none

module tb_hazard_unit_mc;

  localparam int AW  = 5;
  localparam int NS  = 2;
  localparam int TO  = 8;
  localparam int PW  = 4;
  localparam int SAT = (1 << PW) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NS*AW-1:0] rs_d, rs_e;
  logic [NS-1:0]    rs_used_d;
  logic [AW-1:0]    rd_e, rd_m, rd_w;
  logic             reg_write_e, reg_write_m, reg_write_w;
  logic             load_e, branch_taken_e, mc_start_e, mc_done, perf_clr;
  logic [2*NS-1:0]  fwd_sel;
  logic             stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_timeout;
  logic [PW-1:0]    stall_cnt, flush_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state: is a multi-cycle op outstanding, how long, counters.
  bit m_busy = 1'b0;
  int m_bc   = 0;
  bit m_to   = 1'b0;
  int m_scnt = 0;
  int m_fcnt = 0;

  hazard_unit_mc #(
    .REG_AW     (AW),
    .NUM_SRC    (NS),
    .MC_TIMEOUT (TO),
    .PERF_W     (PW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rs_d           (rs_d),
    .rs_used_d      (rs_used_d),
    .rs_e           (rs_e),
    .rd_e           (rd_e),
    .rd_m           (rd_m),
    .rd_w           (rd_w),
    .reg_write_e    (reg_write_e),
    .reg_write_m    (reg_write_m),
    .reg_write_w    (reg_write_w),
    .load_e         (load_e),
    .branch_taken_e (branch_taken_e),
    .mc_start_e     (mc_start_e),
    .mc_done        (mc_done),
    .perf_clr       (perf_clr),
    .fwd_sel        (fwd_sel),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .stall_e        (stall_e),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .flush_m        (flush_m),
    .mc_timeout     (mc_timeout),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2*NS-1:0] exp_fwd();
    logic [2*NS-1:0] r;
    int a;
    r = '0;
    for (int i = 0; i < NS; i++) begin
      a = int'(rs_e[i*AW +: AW]);
      if (a != 0 && reg_write_m && a == int'(rd_m)) r[2*i +: 2] = 2'b10;
      else if (a != 0 && reg_write_w && a == int'(rd_w)) r[2*i +: 2] = 2'b01;
    end
    return r;
  endfunction

  function automatic bit exp_lw();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < NS; i++)
      if (rs_used_d[i] && int'(rs_d[i*AW +: AW]) == int'(rd_e)) hit = 1'b1;
    return load_e && reg_write_e && (int'(rd_e) != 0) && hit;
  endfunction

  // An outstanding op stalls until done arrives or its TO-th busy cycle is reached.
  function automatic bit exp_mc();
    if (!m_busy) return mc_start_e;
    return !mc_done && (m_bc < TO - 1);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_bc   <= 0;
      m_to   <= 1'b0;
      m_scnt <= 0;
      m_fcnt <= 0;
    end else begin
      if (perf_clr) begin
        m_scnt <= 0;
        m_fcnt <= 0;
      end else begin
        if ((exp_lw() || exp_mc()) && m_scnt < SAT) m_scnt <= m_scnt + 1;
        if (branch_taken_e && !exp_mc() && m_fcnt < SAT) m_fcnt <= m_fcnt + 1;
      end
      if (!m_busy) begin
        if (mc_start_e) begin
          m_busy <= 1'b1;
          m_bc   <= 0;
        end
      end else if (mc_done) begin
        m_busy <= 1'b0;
      end else if (m_bc == TO - 1) begin
        m_busy <= 1'b0;
        m_to   <= 1'b1;
      end else begin
        m_bc <= m_bc + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("fwd_sel", fwd_sel, exp_fwd());
      chk("stall_f", stall_f, exp_lw() || exp_mc());
      chk("stall_d", stall_d, exp_lw() || exp_mc());
      chk("stall_e", stall_e, exp_mc());
      chk("flush_m", flush_m, exp_mc());
      chk("flush_e", flush_e, (exp_lw() || branch_taken_e) && !exp_mc());
      chk("flush_d", flush_d, branch_taken_e && !exp_mc());
      chk("mc_timeout", mc_timeout, m_to);
      chk("stall_cnt", stall_cnt, m_scnt);
      chk("flush_cnt", flush_cnt, m_fcnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs_d = '0; rs_e = '0; rs_used_d = '0;
    rd_e = '0; rd_m = '0; rd_w = '0;
    reg_write_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
    load_e = 1'b0; branch_taken_e = 1'b0;
    mc_start_e = 1'b0; mc_done = 1'b0; perf_clr = 1'b0;
  endtask

  task automatic set_lw(input int rd, input int s1, input int s0, input logic [NS-1:0] used);
    load_e = 1'b1; reg_write_e = 1'b1;
    rd_e = AW'(rd);
    rs_d = {AW'(s1), AW'(s0)};
    rs_used_d = used;
  endtask

  initial begin
    idle_inputs();
    tick();
    tick();
    chk_en = 1'b1;
    #1;
    chk("reset stall_cnt", stall_cnt, 0);
    chk("reset flush_cnt", flush_cnt, 0);
    chk("reset mc_timeout", mc_timeout, 0);
    chk("reset stall_e", stall_e, 0);
    reset = 1'b1;
    tick();

    // Forwarding priority and x0 exclusion
    rs_e = {AW'(4), AW'(3)}; rd_m = 5'd3; rd_w = 5'd3; reg_write_m = 1'b1; reg_write_w = 1'b1;
    #1; chk("fwd M prio", fwd_sel[1:0], 2'b10);
    rd_m = 5'd4;
    #1; chk("fwd W", fwd_sel[1:0], 2'b01);
    chk("fwd src1 M", fwd_sel[3:2], 2'b10);
    rs_e = '0; rd_m = '0;
    #1; chk("fwd x0", fwd_sel, 4'b0000);
    tick();
    idle_inputs();

    // Load-use with per-source used qualification
    set_lw(5, 5, 0, 2'b01);
    #1; chk("lw unused", stall_f, 0);
    rs_used_d = 2'b10;
    #1; chk("lw stall_f", stall_f, 1);
    chk("lw stall_d", stall_d, 1);
    chk("lw flush_e", flush_e, 1);
    chk("lw flush_d", flush_d, 0);
    rd_e = '0; rs_used_d = 2'b11;
    #1; chk("lw rd x0", stall_f, 0);
    tick();
    idle_inputs();

    // Multi-cycle op completing at cycle 4
    perf_clr = 1'b1; tick(); perf_clr = 1'b0;
    mc_start_e = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1; chk("mc stall cycle", stall_e, 1);
      chk("mc flush_m cycle", flush_m, 1);
      tick();
    end
    mc_done = 1'b1;
    #1; chk("mc done stall_f", stall_f, 0);
    chk("mc done stall_e", stall_e, 0);
    tick();
    idle_inputs();
    #1; chk("mc stall_cnt", stall_cnt, 4);

    // Branch in IDLE, then branch + load-use while BUSY
    branch_taken_e = 1'b1;
    #1; chk("br idle flush_d", flush_d, 1);
    chk("br idle flush_e", flush_e, 1);
    tick();
    branch_taken_e = 1'b0; mc_start_e = 1'b1;
    tick();
    mc_start_e = 1'b0; branch_taken_e = 1'b1;
    set_lw(5, 5, 0, 2'b10);
    #1; chk("br busy flush_d", flush_d, 0);
    chk("br busy flush_e", flush_e, 0);
    chk("br busy stall_e", stall_e, 1);
    mc_done = 1'b1;
    tick();
    idle_inputs();

    // Watchdog: no done ever arrives
    mc_start_e = 1'b1;
    tick();
    mc_start_e = 1'b0;
    for (int j = 0; j < TO - 1; j++) begin
      #1; chk("to busy stall", stall_e, 1);
      tick();
    end
    #1; chk("to release stall", stall_e, 0);
    chk("to flag pre-edge", mc_timeout, 0);
    tick();
    chk("to flag set", mc_timeout, 1);
    tick(); tick();
    chk("to flag sticky", mc_timeout, 1);

    // Reset in the middle of BUSY
    mc_start_e = 1'b1; tick(); mc_start_e = 1'b0; tick();
    reset = 1'b0;
    #1; chk("rst busy stall_e", stall_e, 0);
    chk("rst mc_timeout", mc_timeout, 0);
    chk("rst stall_cnt", stall_cnt, 0);
    chk("rst flush_cnt", flush_cnt, 0);
    tick();
    reset = 1'b1;
    #1; chk("rst idle after", stall_e, 0);
    tick();

    // Counter saturation and clear priority
    perf_clr = 1'b1; tick(); perf_clr = 1'b0;
    set_lw(7, 7, 7, 2'b01);
    for (int j = 0; j < 20; j++) tick();
    chk("stall_cnt sat", stall_cnt, 15);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    chk("perf_clr wins", stall_cnt, 0);
    idle_inputs();
    tick();

    // Randomized run
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NS; i++) begin
        rs_d[i*AW +: AW] = AW'($urandom_range(0, 3));
        rs_e[i*AW +: AW] = AW'($urandom_range(0, 3));
      end
      rs_used_d      = NS'($urandom);
      rd_e           = AW'($urandom_range(0, 3));
      rd_m           = AW'($urandom_range(0, 3));
      rd_w           = AW'($urandom_range(0, 3));
      reg_write_e    = 1'($urandom_range(0, 1));
      reg_write_m    = 1'($urandom_range(0, 1));
      reg_write_w    = 1'($urandom_range(0, 1));
      load_e         = ($urandom_range(0, 2) == 0);
      branch_taken_e = ($urandom_range(0, 5) == 0);
      mc_start_e     = ($urandom_range(0, 3) == 0);
      mc_done        = ($urandom_range(0, 7) == 0);
      perf_clr       = ($urandom_range(0, 49) == 0);
      reset          = ($urandom_range(0, 399) != 0);
      tick();
    end
    reset = 1'b1;
    idle_inputs();
    tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
